debounce_fsm: RTL and testbench
===============================

Name: debounce_fsm

Overview:
- Consumer end of the sample-tick interface. Takes the periodic 1-cycle `tick` strobe from the tick generator and a raw, bouncy push-button level.
- Produces a clean debounced level plus single-cycle press and release strobes.
- Sits between the board button and the downstream counter. `db_press` is the counter's increment enable.

Parameters:
- N_TICKS, 4: consecutive ticks the synchronized input must stay stable before a level change is accepted. Legal range 1..2**CNT_W.
- CNT_W, 3: width of the internal tick counter.

Ports:
- clk, input, 1: system clock, all logic on rising edge.
- reset, input, 1: reset, asynchronous, active-high.
- tick, input, 1: sample strobe, high exactly one cycle per sample period. Any spacing ≥1 cycle is legal.
- btn_in, input, 1: raw asynchronous button level.
- db_level, output, 1: debounced button level.
- db_press, output, 1: one-cycle strobe on accepted 0→1 change.
- db_release, output, 1: one-cycle strobe on accepted 1→0 change.

Behaviour:
- Synchronizer:
  - btn_in passes through 2 flops to give btn_s. btn_s reflects btn_in 2 clk edges later.
  - Both flops reset to 0.
- States: ZERO, WAIT1, ONE, WAIT0 (2-bit encoded).
  - Registered: state, count[CNT_W-1:0], db_press, db_release.
- Reset values:
  - state = ZERO, count = 0, both synchronizer flops = 0.
  - db_level = 0, db_press = 0, db_release = 0.
  - Reset mid-operation aborts any WAIT state immediately. No strobe is emitted.
- ZERO:
  - If btn_s = 1: go WAIT1, count ← 0.
  - Otherwise stay.
  - tick is ignored in ZERO.
- WAIT1:
  - If btn_s = 0: go ZERO, count ← 0. This has priority over tick in the same cycle.
  - Else if tick = 1 and count == N_TICKS-1: go ONE, db_press ← 1 for that single next cycle.
  - Else if tick = 1: count ← count+1.
  - Else hold.
- ONE:
  - If btn_s = 0: go WAIT0, count ← 0.
  - Otherwise stay.
- WAIT0: mirror of WAIT1.
  - btn_s = 1 → back to ONE, count ← 0, no strobe.
  - On the N_TICKS-th qualifying tick → ZERO, db_release ← 1 for one cycle.
- Tick counting:
  - A tick in the same cycle as the ZERO→WAIT1 (or ONE→WAIT0) transition is not counted.
  - Counting starts with the first tick seen while already in the WAIT state.
- db_level:
  - = 1 in ONE and WAIT0, 0 in ZERO and WAIT1. Decoded from registered state, no glitch.
  - Rises in the same cycle db_press is high. Falls in the same cycle db_release is high.
- Strobes:
  - db_press and db_release are never high together.
  - Each is high for exactly 1 cycle per accepted transition.
- Counter:
  - Never exceeds N_TICKS-1, so no wrap.
  - N_TICKS = 1 means the first qualifying tick accepts the change.
- Latency: btn_in edge → db_level change = 2 sync cycles + 1 cycle into WAIT + N_TICKS tick periods + 1 cycle.
- Held input: continuous btn_in = 1 yields exactly one db_press. No repeats.

Test Plan:
- Reset check: assert reset, btn_in = 1, ticks running → db_level = 0, db_press = 0, db_release = 0 throughout reset. After deassert, db_press occurs only after 4 qualifying ticks.
- Clean press: N_TICKS = 4, tick every 10 cycles, btn_in 0→1 held → db_press high exactly 1 cycle, coincident with db_level rising, on the 4th tick after entering WAIT1. No further db_press while held.
- Bounce: btn_in toggles 1,0,1,0 with each high phase spanning 2 ticks, then stable 1 → no strobe during bounce. Single db_press after 4 ticks of stable 1.
- Release: from ONE, btn_in → 0 held → db_release 1 cycle on the 4th tick, db_level → 0. A 3-tick-long low glitch instead → returns to ONE, no db_release, db_level stays 1.
- Simultaneous drop and tick: in WAIT1 with count = 3, btn_s falls in the same cycle as tick → state ZERO, no db_press.
- Reset mid-WAIT1 with count = 2 → all outputs 0 immediately. After release with btn_in still 1, 4 fresh ticks are required before db_press.

Source files
------------

// File: rtl/debounce_fsm.sv
// Push-button debouncer: 2-flop synchronizer plus a tick-qualified FSM that
// produces a clean level and single-cycle press/release strobes.
module debounce_fsm #(
    parameter int N_TICKS = 4,
    parameter int CNT_W   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_in,
    output logic db_level,
    output logic db_press,
    output logic db_release
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TICKS - 1);

    logic [1:0]       sync;
    logic             btn_s;
    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic             press_n, release_n;

    assign btn_s = sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync       <= 2'b00;
            state      <= ZERO;
            count      <= '0;
            db_press   <= 1'b0;
            db_release <= 1'b0;
        end else begin
            sync       <= {sync[0], btn_in};
            state      <= state_n;
            count      <= count_n;
            db_press   <= press_n;
            db_release <= release_n;
        end
    end

    // Losing the candidate level always wins over a coincident tick.
    always_comb begin
        state_n   = state;
        count_n   = count;
        press_n   = 1'b0;
        release_n = 1'b0;
        case (state)
            ZERO: begin
                if (btn_s) begin
                    state_n = WAIT1;
                    count_n = '0;
                end
            end
            WAIT1: begin
                if (!btn_s) begin
                    state_n = ZERO;
                    count_n = '0;
                end else if (tick) begin
                    if (count == LAST) begin
                        state_n = ONE;
                        count_n = '0;
                        press_n = 1'b1;
                    end else begin
                        count_n = count + CNT_W'(1);
                    end
                end
            end
            ONE: begin
                if (!btn_s) begin
                    state_n = WAIT0;
                    count_n = '0;
                end
            end
            WAIT0: begin
                if (btn_s) begin
                    state_n = ONE;
                    count_n = '0;
                end else if (tick) begin
                    if (count == LAST) begin
                        state_n   = ZERO;
                        count_n   = '0;
                        release_n = 1'b1;
                    end else begin
                        count_n = count + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = ZERO;
                count_n = '0;
            end
        endcase
    end

    assign db_level = (state == ONE) || (state == WAIT0);

endmodule

// File: tb/tb_debounce_fsm.sv
// Bench for debounce_fsm: vector table, directed corner sequences and random
// stimulus compared against a stability-counting reference model.
module tb_debounce_fsm;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset, tick, btn_in;
    logic db_level, db_press, db_release;

    always #5 clk = ~clk;

    debounce_fsm #(.N_TICKS(N), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .tick(tick), .btn_in(btn_in),
        .db_level(db_level), .db_press(db_press), .db_release(db_release)
    );

    int checks = 0, passed = 0, cyc = 0;
    int n_press = 0, n_rel = 0;

    // Model: accepted level plus how many ticks the synchronized input has
    // disagreed with it; the first disagreeing cycle only arms the count.
    logic [1:0] m_sync;
    logic       m_level, m_pend, m_press, m_rel;
    int         m_ticks;

    typedef struct {
        logic       btn;
        logic       tk;
        logic [2:0] exp;
    } vec_t;
    vec_t tbl[16];

    task automatic model_reset();
        m_sync = 2'b00; m_level = 0; m_pend = 0;
        m_press = 0; m_rel = 0; m_ticks = 0;
    endtask

    task automatic model_step(input logic b, input logic t);
        logic bs;
        bs = m_sync[1];
        m_press = 0; m_rel = 0;
        if (bs == m_level) begin
            m_pend = 0; m_ticks = 0;
        end else if (!m_pend) begin
            m_pend = 1; m_ticks = 0;
        end else if (t) begin
            m_ticks++;
            if (m_ticks == N) begin
                m_level = !m_level;
                m_press = m_level;
                m_rel   = !m_level;
                m_pend  = 0; m_ticks = 0;
            end
        end
        m_sync = {m_sync[0], b};
    endtask

    task automatic chk(input string name, input logic [2:0] exp);
        checks++;
        if ({db_level, db_press, db_release} === exp) passed++;
        else $display("FAIL %s cyc=%0d got lvl/prs/rel=%b want=%b",
                      name, cyc, {db_level, db_press, db_release}, exp);
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, exp);
    endtask

    task automatic step(input logic b, input logic t, input logic r);
        btn_in = b; tick = t; reset = r;
        if (r) model_reset();
        else   model_step(b, t);
        @(posedge clk); #1;
        cyc++;
        if (db_press)   n_press++;
        if (db_release) n_rel++;
        chk("model", {m_level, m_press, m_rel});
    endtask

    task automatic run(input logic b, input int n, input int period);
        for (int i = 0; i < n; i++) step(b, (cyc % period) == 0, 1'b0);
    endtask

    initial begin
        int idx;
        logic hold_b;
        reset = 1; tick = 0; btn_in = 0;
        model_reset();

        // Rows 1-8 press with a tick every cycle, rows 9-16 release.
        for (int i = 0; i < 16; i++) begin
            tbl[i].btn = (i < 8);
            tbl[i].tk  = 1'b1;
            tbl[i].exp = (i < 6) ? 3'b000 : (i == 6) ? 3'b110 :
                         (i < 14) ? 3'b100 : (i == 14) ? 3'b001 : 3'b000;
        end

        step(0, 0, 1); step(0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].btn, tbl[i].tk, 1'b0);
            chk($sformatf("table%0d", i), tbl[i].exp);
        end

        // Held in reset with the button down and ticks running.
        for (int i = 0; i < 12; i++) begin
            step(1, (i % 3) == 0, 1);
            chk("reset_hold", 3'b000);
        end
        n_press = 0;
        run(1, 80, 10);
        chk_int("held_one_press", n_press, 1);
        chk("held_level", 3'b100);

        n_rel = 0;
        run(0, 80, 10);
        chk_int("release_count", n_rel, 1);
        chk("release_level", 3'b000);

        n_press = 0;
        run(1, 100, 10);
        chk_int("clean_press", n_press, 1);
        run(0, 80, 10);

        // Bounce: high phases last two ticks each.
        n_press = 0;
        run(1, 20, 10); run(0, 20, 10); run(1, 20, 10); run(0, 20, 10);
        chk_int("bounce_no_press", n_press, 0);
        run(1, 80, 10);
        chk_int("bounce_then_press", n_press, 1);

        // Three-tick low glitch from ONE.
        n_rel = 0;
        run(0, 30, 10); run(1, 60, 10);
        chk_int("glitch_no_release", n_rel, 0);
        chk("glitch_level", 3'b100);
        run(0, 80, 10);

        // Drop reaches the FSM on the same cycle as the would-be 4th tick.
        n_press = 0;
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        step(1, 1, 0); step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
        run(0, 10, 10);
        chk_int("drop_vs_tick", n_press, 0);
        chk("drop_level", 3'b000);

        // Reset in WAIT1 with two ticks counted, button still held.
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        step(1, 1, 0); step(1, 1, 0);
        step(1, 1, 1);
        chk("mid_reset", 3'b000);
        step(1, 0, 1);
        n_press = 0; idx = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1, 1, 0);
            if (db_press && idx < 0) idx = i;
        end
        chk_int("mid_reset_latency", idx, 7);
        chk_int("mid_reset_presses", n_press, 1);

        // Random: sticky button, random tick spacing, rare resets.
        hold_b = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) hold_b = ~hold_b;
            step(hold_b, $urandom_range(0, 2) == 0, $urandom_range(0, 599) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
